// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel structs shared by hosts, buffers and the crossbar
package tlul_pkg;

    localparam logic [2:0] OP_PUT_FULL_DATA   = 3'd0;
    localparam logic [2:0] OP_GET             = 3'd4;
    localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/xbar_port_pkg.sv
// rtl/xbar_port_pkg.sv - payload types and limits for the per-host crossbar buffer
package xbar_port_pkg;

    localparam int XBAR_PORT_MAX_DEPTH = 16;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [1:0]  size;
        logic [7:0]  source;
        logic [31:0] address;
        logic [3:0]  mask;
        logic [31:0] data;
    } tl_a_fields_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [1:0]  size;
        logic [7:0]  source;
        logic        sink;
        logic [31:0] data;
        logic        error;
    } tl_d_fields_t;

endpackage

// File: rtl/xbar_port_fifo.sv
// rtl/xbar_port_fifo.sv - synchronous valid/ready FIFO, no bypass, ready from registered state only
module xbar_port_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A full FIFO refuses a push even when it pops in the same cycle.
    always_comb begin
        in_ready  = (count_q != CNT_W'(DEPTH));
        out_valid = (count_q != '0);
        out_data  = mem_q[rd_ptr_q];
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/xbar_host_port_buf.sv
// rtl/xbar_host_port_buf.sv - per-host A/D buffering with an outstanding-request cap
module xbar_host_port_buf
    import tlul_pkg::*;
    import xbar_port_pkg::*;
#(
    parameter int REQ_DEPTH = 2,
    parameter int RSP_DEPTH = 2,
    parameter int MAX_OUTST = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  tl_h2d_t                        tl_host_i,
    output tl_d2h_t                        tl_host_o,
    output tl_h2d_t                        tl_xbar_o,
    input  tl_d2h_t                        tl_xbar_i,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt_o,
    output logic                           idle_o
);

    localparam int OW = $clog2(MAX_OUTST + 1);

    if (REQ_DEPTH < 1 || REQ_DEPTH > XBAR_PORT_MAX_DEPTH) begin : g_bad_req_depth
        $error("REQ_DEPTH out of range 1..16");
    end
    if (RSP_DEPTH < 1 || RSP_DEPTH > XBAR_PORT_MAX_DEPTH) begin : g_bad_rsp_depth
        $error("RSP_DEPTH out of range 1..16");
    end
    if (MAX_OUTST < 1 || MAX_OUTST > RSP_DEPTH) begin : g_bad_max_outst
        $error("MAX_OUTST out of range 1..RSP_DEPTH");
    end

    tl_a_fields_t  req_in, req_out;
    tl_d_fields_t  rsp_in, rsp_out;
    logic          req_in_valid, req_in_ready, req_out_valid;
    logic          rsp_in_ready, rsp_out_valid;
    logic          cap_ok, host_a_ready, a_accept, d_handshake;
    logic [OW-1:0] outst_cnt_q, outst_cnt_d;

    // The cap gates the FIFO push so a refused host request never enters the queue.
    always_comb begin
        cap_ok       = (outst_cnt_q < OW'(MAX_OUTST));
        host_a_ready = req_in_ready && cap_ok;
        req_in_valid = tl_host_i.a_valid && cap_ok;
        a_accept     = tl_host_i.a_valid && host_a_ready;
        d_handshake  = rsp_out_valid && tl_host_i.d_ready;
        outst_cnt_d  = outst_cnt_q;
        case ({a_accept, d_handshake})
            2'b10:   outst_cnt_d = outst_cnt_q + OW'(1);
            2'b01:   outst_cnt_d = (outst_cnt_q == '0) ? '0 : outst_cnt_q - OW'(1);
            default: outst_cnt_d = outst_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outst_cnt_q <= '0;
        end else begin
            outst_cnt_q <= outst_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(d_handshake && outst_cnt_q == '0));
        end
    end

    always_comb begin
        req_in.opcode  = tl_host_i.a_opcode;
        req_in.param   = tl_host_i.a_param;
        req_in.size    = tl_host_i.a_size;
        req_in.source  = tl_host_i.a_source;
        req_in.address = tl_host_i.a_address;
        req_in.mask    = tl_host_i.a_mask;
        req_in.data    = tl_host_i.a_data;

        rsp_in.opcode  = tl_xbar_i.d_opcode;
        rsp_in.param   = tl_xbar_i.d_param;
        rsp_in.size    = tl_xbar_i.d_size;
        rsp_in.source  = tl_xbar_i.d_source;
        rsp_in.sink    = tl_xbar_i.d_sink;
        rsp_in.data    = tl_xbar_i.d_data;
        rsp_in.error   = tl_xbar_i.d_error;
    end

    xbar_port_fifo #(
        .T     (tl_a_fields_t),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (req_in_valid),
        .in_ready  (req_in_ready),
        .in_data   (req_in),
        .out_valid (req_out_valid),
        .out_ready (tl_xbar_i.a_ready),
        .out_data  (req_out)
    );

    xbar_port_fifo #(
        .T     (tl_d_fields_t),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (tl_xbar_i.d_valid),
        .in_ready  (rsp_in_ready),
        .in_data   (rsp_in),
        .out_valid (rsp_out_valid),
        .out_ready (tl_host_i.d_ready),
        .out_data  (rsp_out)
    );

    always_comb begin
        tl_xbar_o           = '0;
        tl_xbar_o.a_valid   = req_out_valid;
        tl_xbar_o.a_opcode  = req_out.opcode;
        tl_xbar_o.a_param   = req_out.param;
        tl_xbar_o.a_size    = req_out.size;
        tl_xbar_o.a_source  = req_out.source;
        tl_xbar_o.a_address = req_out.address;
        tl_xbar_o.a_mask    = req_out.mask;
        tl_xbar_o.a_data    = req_out.data;
        tl_xbar_o.d_ready   = rsp_in_ready;

        tl_host_o           = '0;
        tl_host_o.d_valid   = rsp_out_valid;
        tl_host_o.d_opcode  = rsp_out.opcode;
        tl_host_o.d_param   = rsp_out.param;
        tl_host_o.d_size    = rsp_out.size;
        tl_host_o.d_source  = rsp_out.source;
        tl_host_o.d_sink    = rsp_out.sink;
        tl_host_o.d_data    = rsp_out.data;
        tl_host_o.d_error   = rsp_out.error;
        tl_host_o.a_ready   = host_a_ready;

        outst_cnt_o         = outst_cnt_q;
        idle_o              = !req_out_valid && !rsp_out_valid && (outst_cnt_q == '0);
    end

endmodule

// File: tb/tb_xbar_host_port_buf.sv
// tb/tb_xbar_host_port_buf.sv - directed self-checking bench for xbar_host_port_buf
module tb_xbar_host_port_buf;
    import tlul_pkg::*;

    logic       clk;
    logic       rst;
    tl_h2d_t    h_i, x_o, h4_i, x4_o;
    tl_d2h_t    h_o, x_i, h4_o, x4_i;
    logic [1:0] cnt;
    logic [2:0] cnt4;
    logic       idle, idle4;
    int         errors;
    int         checks;

    xbar_host_port_buf dut (
        .clk         (clk),
        .rst         (rst),
        .tl_host_i   (h_i),
        .tl_host_o   (h_o),
        .tl_xbar_o   (x_o),
        .tl_xbar_i   (x_i),
        .outst_cnt_o (cnt),
        .idle_o      (idle)
    );

    xbar_host_port_buf #(
        .REQ_DEPTH (2),
        .RSP_DEPTH (4),
        .MAX_OUTST (4)
    ) dut4 (
        .clk         (clk),
        .rst         (rst),
        .tl_host_i   (h4_i),
        .tl_host_o   (h4_o),
        .tl_xbar_o   (x4_o),
        .tl_xbar_i   (x4_i),
        .outst_cnt_o (cnt4),
        .idle_o      (idle4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_ready"},  h_o.a_ready, 1);
        chk({tag, "_d_valid"},  h_o.d_valid, 0);
        chk({tag, "_x_a_valid"}, x_o.a_valid, 0);
        chk({tag, "_x_d_ready"}, x_o.d_ready, 1);
        chk({tag, "_cnt"},      cnt, 0);
        chk({tag, "_idle"},     idle, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        h_i  = '0; h_i.d_ready  = 1'b1;
        x_i  = '0; x_i.a_ready  = 1'b1;
        h4_i = '0; h4_i.d_ready = 1'b1;
        x4_i = '0; x4_i.a_ready = 1'b1;
        step();
        step();

        // Reset then idle
        chk_reset_outputs("reset");
        chk("reset4_idle", idle4, 1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_a_ready", h_o.a_ready, 1);
            chk("hold_x_a_valid", x_o.a_valid, 0);
            chk("hold_cnt", cnt, 0);
            chk("hold_idle", idle, 1);
        end

        // Single Get
        h_i.a_valid   = 1'b1;
        h_i.a_opcode  = OP_GET;
        h_i.a_address = 32'h4000_0010;
        h_i.a_source  = 8'd3;
        h_i.a_size    = 2'd2;
        h_i.a_mask    = 4'hf;
        chk("get_a_ready", h_o.a_ready, 1);
        step();
        h_i.a_valid = 1'b0;
        chk("get_x_a_valid", x_o.a_valid, 1);
        chk("get_x_address", x_o.a_address, 64'h4000_0010);
        chk("get_x_source", x_o.a_source, 3);
        chk("get_x_opcode", x_o.a_opcode, 4);
        chk("get_x_mask", x_o.a_mask, 4'hf);
        chk("get_x_size", x_o.a_size, 2);
        chk("get_cnt1", cnt, 1);
        chk("get_not_idle", idle, 0);
        step();
        chk("get_x_popped", x_o.a_valid, 0);
        chk("get_x_d_ready", x_o.d_ready, 1);
        x_i.d_valid  = 1'b1;
        x_i.d_opcode = OP_ACCESS_ACK_DATA;
        x_i.d_data   = 32'hDEAD_BEEF;
        x_i.d_source = 8'd3;
        step();
        x_i.d_valid = 1'b0;
        chk("get_d_valid", h_o.d_valid, 1);
        chk("get_d_data", h_o.d_data, 64'hDEAD_BEEF);
        chk("get_d_source", h_o.d_source, 3);
        chk("get_d_opcode", h_o.d_opcode, 1);
        chk("get_cnt_before_hs", cnt, 1);
        step();
        chk("get_d_done", h_o.d_valid, 0);
        chk("get_cnt0", cnt, 0);
        chk("get_idle", idle, 1);

        // Outstanding cap: three back-to-back Puts, no responses
        h_i.a_valid   = 1'b1;
        h_i.a_opcode  = OP_PUT_FULL_DATA;
        h_i.a_address = 32'h0000_0100;
        h_i.a_source  = 8'd1;
        h_i.a_data    = 32'h1111_0000;
        chk("cap_a_ready0", h_o.a_ready, 1);
        step();
        h_i.a_address = 32'h0000_0104;
        h_i.a_source  = 8'd2;
        chk("cap_cnt1", cnt, 1);
        chk("cap_a_ready1", h_o.a_ready, 1);
        step();
        h_i.a_address = 32'h0000_0108;
        h_i.a_source  = 8'd3;
        chk("cap_cnt2", cnt, 2);
        chk("cap_a_ready_low", h_o.a_ready, 0);
        chk("cap_fwd_second", x_o.a_address, 64'h104);
        step();
        chk("cap_cnt_held", cnt, 2);
        chk("cap_a_ready_held", h_o.a_ready, 0);
        h_i.a_valid = 1'b0;
        x_i.d_valid  = 1'b1;
        x_i.d_opcode = OP_ACCESS_ACK;
        x_i.d_source = 8'd1;
        x_i.d_data   = 32'h0;
        step();
        x_i.d_valid = 1'b0;
        chk("cap_d_valid", h_o.d_valid, 1);
        chk("cap_a_ready_pre_hs", h_o.a_ready, 0);
        step();
        chk("cap_cnt_after_d", cnt, 1);
        chk("cap_a_ready_rise", h_o.a_ready, 1);

        // Simultaneous A accept and D handshake at count 1
        h_i.d_ready  = 1'b0;
        x_i.d_valid  = 1'b1;
        x_i.d_source = 8'd2;
        step();
        x_i.d_valid = 1'b0;
        chk("sim_d_queued", h_o.d_valid, 1);
        chk("sim_cnt_pre", cnt, 1);
        h_i.a_valid   = 1'b1;
        h_i.a_address = 32'h0000_0200;
        h_i.a_source  = 8'd4;
        h_i.d_ready   = 1'b1;
        chk("sim_a_ready", h_o.a_ready, 1);
        step();
        h_i.a_valid = 1'b0;
        chk("sim_cnt_same", cnt, 1);
        chk("sim_d_popped", h_o.d_valid, 0);
        chk("sim_x_address", x_o.a_address, 64'h200);
        x_i.d_valid  = 1'b1;
        x_i.d_source = 8'd4;
        step();
        x_i.d_valid = 1'b0;
        step();
        chk("sim_drain_cnt", cnt, 0);
        chk("sim_drain_idle", idle, 1);

        // Reset mid-operation
        x_i.a_ready   = 1'b0;
        h_i.d_ready   = 1'b0;
        h_i.a_valid   = 1'b1;
        h_i.a_address = 32'h0000_0300;
        step();
        h_i.a_address = 32'h0000_0304;
        step();
        h_i.a_valid = 1'b0;
        chk("mid_cnt2", cnt, 2);
        chk("mid_x_a_valid", x_o.a_valid, 1);
        x_i.d_valid = 1'b1;
        x_i.d_data  = 32'hCAFE_F00D;
        step();
        x_i.d_valid = 1'b0;
        chk("mid_d_queued", h_o.d_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("mid_reset");
        x_i.a_ready = 1'b1;
        h_i.d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_no_d", h_o.d_valid, 0);
            chk("mid_no_a", x_o.a_valid, 0);
        end

        // Backpressure fill on the deeper-cap instance
        x4_i.a_ready   = 1'b0;
        h4_i.a_valid   = 1'b1;
        h4_i.a_opcode  = OP_PUT_FULL_DATA;
        h4_i.a_address = 32'h0000_0500;
        chk("bp_a_ready0", h4_o.a_ready, 1);
        step();
        h4_i.a_address = 32'h0000_0504;
        chk("bp_cnt1", cnt4, 1);
        chk("bp_a_ready1", h4_o.a_ready, 1);
        step();
        h4_i.a_address = 32'h0000_0508;
        chk("bp_cnt2", cnt4, 2);
        chk("bp_full_a_ready", h4_o.a_ready, 0);
        step();
        chk("bp_full_held", h4_o.a_ready, 0);
        chk("bp_cnt_held", cnt4, 2);
        x4_i.a_ready = 1'b1;
        chk("bp_head0", x4_o.a_address, 64'h500);
        step();
        h4_i.a_valid = 1'b0;
        chk("bp_fwd1_valid", x4_o.a_valid, 1);
        chk("bp_fwd1_addr", x4_o.a_address, 64'h504);
        chk("bp_push_refused_cnt", cnt4, 2);
        chk("bp_slot_freed", h4_o.a_ready, 1);
        step();
        chk("bp_drained", x4_o.a_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
